edge_event_unit: RTL and testbench
==================================

// Module: edge_event_unit
// PURPOSE
//  Multi-channel successor of the single-signal edge detector. Each channel synchronises an async
//  input, glitch-filters it, emits rise/fall pulses, and raises a mode-qualified sticky event flag
//  with a saturating event counter. A combined irq collects all flags. Sits between raw pins or SPI
//  status lines and the register/interrupt logic.
// PARAMETERS
//  CHANNELS       8   number of independent input channels
//  SYNC_STAGES    2   synchroniser flops per channel (legal >=2)
//  FILTER_CYCLES  4   consecutive differing samples before level accepted (0 = filter bypass)
//  CNT_W          8   width of per-channel saturating event counter
// PORTS
//  clock         in   1               system clock, all logic on posedge
//  rst           in   1               reset, synchronous, active-low
//  semnal        in   CHANNELS        asynchronous inputs
//  mode          in   2*CHANNELS      per-channel qualifier, ch i = mode[2i+1:2i]
//  clr           in   CHANNELS        per-channel clear pulse for pending + count
//  pos_detected  out  CHANNELS        1-cycle pulse on accepted rising edge (mode-independent)
//  neg_detected  out  CHANNELS        1-cycle pulse on accepted falling edge (mode-independent)
//  level         out  CHANNELS        filtered, synchronised level
//  pending       out  CHANNELS        sticky qualified-event flag
//  event_count   out  CHANNELS*CNT_W  ch i = [CNT_W*i +: CNT_W], saturating
//  irq           out  1               registered OR of pending
// BEHAVIOUR
//  - Reset (rst=0 at posedge): sync chain, level, filter counters, pulses, pending, counts, irq all 0.
//  - Priming: SYNC_STAGES+1 cycles after rst deasserts, level loads directly from the sync output and
//    no pulses are generated; an input held high through reset never yields a spurious edge.
//  - Sync: per channel shift chain; sync_q = last stage.
//  - Filter (FILTER_CYCLES>0): per channel counter cnt. If sync_q==level, cnt<=0. Otherwise cnt
//    increments; on the cycle cnt==FILTER_CYCLES-1 and still differing, level<=sync_q and cnt<=0.
//    Glitch shorter than FILTER_CYCLES samples: no level change, no pulse.
//  - FILTER_CYCLES==0: level<=sync_q each cycle.
//  - Pulses registered, high for exactly the one cycle in which level changes:
//    pos = level 0->1, neg = level 1->0. Never both high in the same cycle on one channel.
//  - Latency: new input level captured into sync stage 1 at edge E0 -> pulse high after edge
//    E0+SYNC_STAGES+max(FILTER_CYCLES,1)-1 (defaults: 6 edges counted from and including E0).
//  - mode: 00 OFF, 01 RISE, 10 FALL, 11 BOTH. Qualified edge q = pulse matching mode.
//    mode is sampled in the same cycle as the pulse; a mode change affects only later edges.
//  - pending[i]: set on q, cleared on clr[i]; q and clr in the same cycle -> pending stays 1.
//  - event_count[i]: +1 on q, saturates at 2^CNT_W-1 (no wrap). clr[i] -> 0.
//    clr and q in the same cycle -> 1.
//  - irq <= |pending, one cycle after pending changes.
//  - Reset mid-operation: all state cleared at that edge, partial filter counts discarded,
//    priming restarts.
// STRUCTURE
//  - Package edge_pkg: localparams EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10,
//    EDGE_BOTH=2'b11; prime-length function.
//  - Sub-module edge_channel: one channel (sync, filter, pulse, pending, counter),
//    instantiated CHANNELS times in a generate loop. Top holds the prime counter and irq.
// TESTING
//  1. Reset with semnal=8'hFF held -> after priming level=8'hFF, zero pulses, pending=0, irq=0.
//  2. ch0 mode=RISE, semnal[0] 0->1 held -> pos_detected[0] single pulse 6 edges after capture,
//     pending[0]=1, count=1, irq=1 one cycle later.
//  3. ch1 3-cycle glitch high (FILTER_CYCLES=4) -> no pulse, level[1]=0. 4-cycle high -> one pos
//     pulse, then one neg pulse on return.
//  4. ch2 mode=FALL, 300 falling edges -> neg_detected pulses 300, count saturates at 255,
//     pending=1. ch3 mode=OFF with same stimulus -> pulses seen, pending=0, count=0.
//  5. clr[0] in the same cycle as a qualified edge -> pending[0]=1, count=1. clr alone -> 0, 0,
//     and irq drops one cycle later.
//  6. rst asserted mid-filter (cnt=2) then released with input high -> all outputs 0, no pulse
//     during priming, level=1 afterwards.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge/event unit.
// Holds the mode encodings and the priming-length helper.
package edge_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Cycles after reset release during which level tracks the synchroniser directly
    function automatic int unsigned prime_len(input int unsigned sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/edge_channel.sv
// One input channel: synchroniser, glitch filter, edge pulses,
// mode-qualified sticky pending flag and saturating event counter.
module edge_channel
    import edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             prime_i,
    input  logic             semnal_i,
    input  logic [1:0]       mode_i,
    input  logic             clr_i,
    output logic             pos_o,
    output logic             neg_o,
    output logic             level_o,
    output logic             pending_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned FC_W    = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
    localparam int unsigned FC_LAST = (FILTER_CYCLES > 0) ? FILTER_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FC_W-1:0]        filt_q, filt_d;
    logic                   level_q, level_d;
    logic                   pos_q, pos_d;
    logic                   neg_q, neg_d;
    logic                   pending_q, pending_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   sync_lvl;
    logic                   qual;

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // Qualification looks at the pulse currently on the outputs and the mode of that same cycle
    assign qual = (pos_q && (mode_i == EDGE_RISE || mode_i == EDGE_BOTH)) ||
                  (neg_q && (mode_i == EDGE_FALL || mode_i == EDGE_BOTH));

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], semnal_i};
        filt_d  = '0;
        level_d = level_q;
        if (prime_i || FILTER_CYCLES == 0) begin
            level_d = sync_lvl;
        end else if (sync_lvl != level_q) begin
            if (filt_q == FC_W'(FC_LAST)) begin
                level_d = sync_lvl;
            end else begin
                filt_d = filt_q + FC_W'(1);
            end
        end

        pos_d     = !prime_i && level_d && !level_q;
        neg_d     = !prime_i && !level_d && level_q;
        pending_d = qual || (pending_q && !clr_i);

        // A clear coinciding with a qualified edge leaves exactly that edge counted
        if (clr_i) begin
            count_d = CNT_W'(qual);
        end else if (qual && count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            sync_q    <= '0;
            filt_q    <= '0;
            level_q   <= 1'b0;
            pos_q     <= 1'b0;
            neg_q     <= 1'b0;
            pending_q <= 1'b0;
            count_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            filt_q    <= filt_d;
            level_q   <= level_d;
            pos_q     <= pos_d;
            neg_q     <= neg_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pos_o     = pos_q;
    assign neg_o     = neg_q;
    assign level_o   = level_q;
    assign pending_o = pending_q;
    assign count_o   = count_q;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge/event unit: per-channel edge_channel instances,
// shared post-reset priming counter and registered combined interrupt.
module edge_event_unit
    import edge_pkg::*;
#(
    parameter int unsigned CHANNELS      = 8,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                      clock,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       semnal,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [CHANNELS-1:0]       clr,
    output logic [CHANNELS-1:0]       pos_detected,
    output logic [CHANNELS-1:0]       neg_detected,
    output logic [CHANNELS-1:0]       level,
    output logic [CHANNELS-1:0]       pending,
    output logic [CHANNELS*CNT_W-1:0] event_count,
    output logic                      irq
);

    localparam int unsigned PRIME_LEN = prime_len(SYNC_STAGES);
    localparam int unsigned PRIME_W   = $clog2(PRIME_LEN + 1);

    logic [PRIME_W-1:0] prime_q, prime_d;
    logic               priming;
    logic               irq_q, irq_d;

    assign priming = (prime_q != PRIME_W'(PRIME_LEN));

    always_comb begin
        prime_d = prime_q;
        if (priming) begin
            prime_d = prime_q + PRIME_W'(1);
        end
        irq_d = |pending;
    end

    always_ff @(posedge clock) begin
        if (!rst) begin
            prime_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            prime_q <= prime_d;
            irq_q   <= irq_d;
        end
    end

    assign irq = irq_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        edge_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clock    (clock),
            .rst      (rst),
            .prime_i  (priming),
            .semnal_i (semnal[g]),
            .mode_i   (mode[2*g +: 2]),
            .clr_i    (clr[g]),
            .pos_o    (pos_detected[g]),
            .neg_o    (neg_detected[g]),
            .level_o  (level[g]),
            .pending_o(pending[g]),
            .count_o  (event_count[CNT_W*g +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_event_unit.sv
// Bench for edge_event_unit: window-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_edge_event_unit;

    localparam int CH    = 8;
    localparam int SS    = 2;
    localparam int FC    = 4;
    localparam int CW    = 8;
    localparam int PRIME = SS + 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clock;
    logic            rst;
    logic [CH-1:0]   semnal;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   pos_detected;
    logic [CH-1:0]   neg_detected;
    logic [CH-1:0]   level;
    logic [CH-1:0]   pending;
    logic [CH*CW-1:0] event_count;
    logic            irq;

    edge_event_unit #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .semnal      (semnal),
        .mode        (mode),
        .clr         (clr),
        .pos_detected(pos_detected),
        .neg_detected(neg_detected),
        .level       (level),
        .pending     (pending),
        .event_count (event_count),
        .irq         (irq)
    );

    int errors = 0;
    int checks = 0;
    int pos_seen[CH];
    int neg_seen[CH];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples since reset release; sync value seen at edge n is the sample from SS edges earlier.
    logic [CH-1:0] raw_hist[$];
    logic [CH-1:0] syn_hist[$];
    logic [CH-1:0] m_level, m_pos, m_neg, m_pend;
    logic          m_irq;
    int            m_cnt[CH];
    bit            started = 0;

    task automatic model_step();
        logic [CH-1:0] sv, nl, qual;
        int n;
        bit all_diff;
        if (!rst) begin
            raw_hist.delete();
            syn_hist.delete();
            m_level = '0; m_pos = '0; m_neg = '0; m_pend = '0; m_irq = 1'b0;
            for (int i = 0; i < CH; i++) m_cnt[i] = 0;
            return;
        end
        for (int i = 0; i < CH; i++)
            qual[i] = (m_pos[i] & mode[2*i]) | (m_neg[i] & mode[2*i+1]);
        m_irq = |m_pend;
        for (int i = 0; i < CH; i++) begin
            if (clr[i]) m_cnt[i] = qual[i] ? 1 : 0;
            else if (qual[i] && m_cnt[i] < CMAX) m_cnt[i] = m_cnt[i] + 1;
        end
        m_pend = qual | (m_pend & ~clr);

        raw_hist.push_back(semnal);
        n  = raw_hist.size();
        sv = (n > SS) ? raw_hist[n-SS-1] : '0;
        syn_hist.push_back(sv);
        if (n <= PRIME || FC == 0) begin
            nl = sv;
        end else begin
            // level flips once the last FC sync samples all disagree with it
            for (int c = 0; c < CH; c++) begin
                all_diff = 1;
                for (int j = 0; j < FC; j++) begin
                    if (n - 1 - j < 0) all_diff = 0;
                    else if (syn_hist[n-1-j][c] == m_level[c]) all_diff = 0;
                end
                nl[c] = all_diff ? ~m_level[c] : m_level[c];
            end
        end
        m_pos   = (n <= PRIME) ? '0 : (nl & ~m_level);
        m_neg   = (n <= PRIME) ? '0 : (~nl & m_level);
        m_level = nl;
    endtask

    initial forever begin
        @(posedge clock);
        model_step();
        started = 1;
    end

    task automatic compare_all();
        logic [CH*CW-1:0] ec;
        for (int i = 0; i < CH; i++) ec[CW*i +: CW] = CW'(m_cnt[i]);
        check("pos_detected", 64'(pos_detected), 64'(m_pos));
        check("neg_detected", 64'(neg_detected), 64'(m_neg));
        check("level",        64'(level),        64'(m_level));
        check("pending",      64'(pending),      64'(m_pend));
        check("event_count",  64'(event_count),  64'(ec));
        check("irq",          64'(irq),          64'(m_irq));
    endtask

    initial forever begin
        @(negedge clock);
        if (started) compare_all();
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < CH; i++) begin
            pos_seen[i] += int'(pos_detected[i]);
            neg_seen[i] += int'(neg_detected[i]);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_seen();
        for (int i = 0; i < CH; i++) begin
            pos_seen[i] = 0;
            neg_seen[i] = 0;
        end
    endtask

    function automatic int total_seen();
        int s = 0;
        for (int i = 0; i < CH; i++) s += pos_seen[i] + neg_seen[i];
        return s;
    endfunction

    int  first_k;
    bit  found;

    initial begin
        rst = 1'b0; semnal = 8'hFF; mode = '0; clr = '0;
        clear_seen();
        ticks(3);

        // Input high through reset: level follows after priming, no edges
        rst = 1'b1;
        clear_seen();
        ticks(6);
        check("t1_level", 64'(level), 64'(8'hFF));
        check("t1_no_pulses", 64'(total_seen()), 64'd0);
        check("t1_pending", 64'(pending), 64'd0);
        check("t1_irq", 64'(irq), 64'd0);

        // Rising edge on ch0 with RISE mode: latency, pending, count, irq
        semnal = 8'h00;
        ticks(10);
        mode[1:0] = 2'b01;
        semnal[0] = 1'b1;
        clear_seen();
        first_k = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (first_k < 0 && pos_detected[0]) first_k = k;
            if (k == 7) begin
                check("t2_pending_set", 64'(pending[0]), 64'd1);
                check("t2_irq_not_yet", 64'(irq), 64'd0);
            end
            if (k == 8) check("t2_irq_set", 64'(irq), 64'd1);
        end
        check("t2_latency", 64'(first_k), 64'd6);
        check("t2_single_pulse", 64'(pos_seen[0]), 64'd1);
        check("t2_count", 64'(event_count[7:0]), 64'd1);

        // Glitch filtering on ch1
        mode[3:2] = 2'b11;
        clear_seen();
        semnal[1] = 1'b1; ticks(3);
        semnal[1] = 1'b0; ticks(10);
        check("t3_glitch_no_pulse", 64'(pos_seen[1]), 64'd0);
        check("t3_glitch_level", 64'(level[1]), 64'd0);
        clear_seen();
        semnal[1] = 1'b1; ticks(4);
        semnal[1] = 1'b0; ticks(12);
        check("t3_pos_once", 64'(pos_seen[1]), 64'd1);
        check("t3_neg_once", 64'(neg_seen[1]), 64'd1);

        // 300 falling edges: ch2 FALL saturates, ch3 OFF never qualifies
        mode[5:4] = 2'b10;
        mode[7:6] = 2'b00;
        clear_seen();
        for (int r = 0; r < 300; r++) begin
            semnal[3:2] = 2'b11; ticks(5);
            semnal[3:2] = 2'b00; ticks(5);
        end
        ticks(10);
        check("t4_ch2_negs", 64'(neg_seen[2]), 64'd300);
        check("t4_ch2_count_sat", 64'(event_count[23:16]), 64'd255);
        check("t4_ch2_pending", 64'(pending[2]), 64'd1);
        check("t4_ch3_negs", 64'(neg_seen[3]), 64'd300);
        check("t4_ch3_pending", 64'(pending[3]), 64'd0);
        check("t4_ch3_count", 64'(event_count[31:24]), 64'd0);

        // Clear racing a qualified edge, then clear alone
        mode = 16'h0001;
        clr = 8'hFF; tick(); clr = '0;
        ticks(2);
        check("t5_all_clear_pending", 64'(pending), 64'd0);
        check("t5_all_clear_count", 64'(event_count), 64'd0);
        check("t5_irq_low", 64'(irq), 64'd0);
        semnal[0] = 1'b0; ticks(10);
        semnal[0] = 1'b1;
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (pos_detected[0]) found = 1;
        end
        check("t5_pulse_seen", 64'(found), 64'd1);
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        check("t5_race_pending", 64'(pending[0]), 64'd1);
        check("t5_race_count", 64'(event_count[7:0]), 64'd1);
        tick();
        clr[0] = 1'b1; tick(); clr[0] = 1'b0;
        check("t5_clr_pending", 64'(pending[0]), 64'd0);
        check("t5_clr_count", 64'(event_count[7:0]), 64'd0);
        check("t5_irq_lags", 64'(irq), 64'd1);
        tick();
        check("t5_irq_drop", 64'(irq), 64'd0);

        // Reset in the middle of a filter run
        semnal[0] = 1'b0; ticks(10);
        semnal[0] = 1'b1; ticks(4);
        rst = 1'b0; ticks(2);
        check("t6_level", 64'(level), 64'd0);
        check("t6_pending", 64'(pending), 64'd0);
        check("t6_count", 64'(event_count), 64'd0);
        check("t6_irq", 64'(irq), 64'd0);
        check("t6_pulses", 64'({pos_detected, neg_detected}), 64'd0);
        rst = 1'b1;
        clear_seen();
        ticks(8);
        check("t6_no_prime_pulse", 64'(total_seen()), 64'd0);
        check("t6_level_after", 64'(level), 64'(8'h01));

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) mode = 16'($urandom);
            for (int i = 0; i < CH; i++)
                if ($urandom_range(5) == 0) semnal[i] = ~semnal[i];
            clr = '0;
            for (int i = 0; i < CH; i++)
                if ($urandom_range(31) == 0) clr[i] = 1'b1;
            rst = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rst = 1'b1; clr = '0;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
